// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, default
// sizing constants and the requester-index width helper.
package uart_arb_pkg;

    typedef logic arb_state_t;

    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_LOCK = 1'b1;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping from N_REQ-1 back to 0.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any_valid
);

    localparam logic [ID_W:0] N_WIDE = (ID_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [ID_W-1:0]    offset;
    logic [ID_W:0]      sum;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        doubled = {valid, valid};
        rotated = doubled[rr_ptr +: N_REQ];
        offset  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = ID_W'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= N_WIDE) begin
            sum = sum - N_WIDE;
        end
        winner    = sum[ID_W-1:0];
        any_valid = |valid;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between
// N_REQ byte producers, with stall timeout and a registered output stage.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_valid,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_ready,
    output logic                         grant_active,
    output logic [id_width(N_REQ)-1:0]   grant_id,
    output logic                         timeout_err
);

    localparam int               ID_W    = id_width(N_REQ);
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   next_ptr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              gnt_valid;
    logic              gnt_last;
    logic [DATA_W-1:0] gnt_data;
    logic              out_free;
    logic              accept;
    logic              stalled;
    logic              timed_out;
    logic              done;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Select the owning requester's lane.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The output register can take a byte when empty or draining this cycle,
    // which also keeps a final byte from being overwritten after release.
    assign out_free  = !tx_valid || tx_ready;
    assign accept    = (state == ST_LOCK) && gnt_valid && out_free;
    assign stalled   = (state == ST_LOCK) && !gnt_valid;
    assign timed_out = (state == ST_LOCK) && !accept && (stall_cnt == CNT_MAX);
    assign done      = accept && gnt_last;
    assign next_ptr  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (any_valid)         next_state = ST_LOCK;
            ST_LOCK: if (done || timed_out) next_state = ST_IDLE;
            default:                        next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_LOCK && out_free) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_id == ID_W'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Grant bookkeeping; the pointer only advances when a packet ends or is cut off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_active <= 1'b0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= timed_out;
            if (state == ST_IDLE && any_valid) begin
                grant_id     <= winner;
                grant_active <= 1'b1;
            end else if (done || timed_out) begin
                grant_active <= 1'b0;
                rr_ptr       <= next_ptr;
            end
        end
    end

    // Only cycles where the owner itself has nothing to send count as stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == ST_IDLE || accept) begin
            stall_cnt <= '0;
        end else if (stalled && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (accept) begin
            tx_valid <= 1'b1;
            tx_data  <= gnt_data;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked cycle by cycle against a model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic            grant_active;
    logic [IW-1:0]   grant_id;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    // Reference model: owner (-1 when free), round-robin start, stall run length,
    // and the byte waiting for the UART.
    int         m_owner;
    int         m_ptr;
    int         m_stall;
    int         m_gid;
    bit         m_txv;
    bit         m_terr;
    logic [7:0] m_txd;

    bit         use_gen;
    int         p_valid;
    int         p_ready;
    logic [7:0] g_byte [N];
    bit         g_last [N];
    int         g_left [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic genNext(input int i);
        if (g_left[i] <= 1) g_left[i] = $urandom_range(1, 4);
        else                g_left[i] = g_left[i] - 1;
        g_byte[i] = 8'($urandom_range(0, 255));
        g_last[i] = (g_left[i] == 1);
    endtask

    task automatic setReq(input int i, input bit v, input logic [7:0] d, input bit l);
        req_valid[i]         = v;
        req_data[i*DW +: DW] = d;
        req_last[i]          = l;
    endtask

    task automatic clearReqs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic modelReset();
        m_owner = -1;
        m_ptr   = 0;
        m_stall = 0;
        m_gid   = 0;
        m_txv   = 0;
        m_txd   = 8'h00;
        m_terr  = 0;
        for (int i = 0; i < N; i++) begin
            g_left[i] = 0;
            genNext(i);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            setReq(i, ($urandom_range(0, 99) < p_valid), g_byte[i], g_last[i]);
        end
        tx_ready = ($urandom_range(0, 99) < p_ready);
    endtask

    task automatic checkOutput();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_owner >= 0 && (!m_txv || tx_ready)) exp_rdy[m_owner] = 1'b1;
        chk("tx_valid", tx_valid, m_txv);
        chk("tx_data", tx_data, m_txd);
        chk("grant_active", grant_active, (m_owner >= 0));
        chk("grant_id", grant_id, m_gid);
        chk("timeout_err", timeout_err, m_terr);
        chk("req_ready", req_ready, exp_rdy);
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic stepModel();
        bit acc;
        bit terr;
        bit nxt_txv;
        int o;
        acc     = 0;
        terr    = 0;
        nxt_txv = m_txv && !tx_ready;
        if (m_owner < 0) begin
            m_stall = 0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_gid   = m_owner;
                end
            end
        end else begin
            o   = m_owner;
            acc = req_valid[o] && (!m_txv || tx_ready);
            if (acc) begin
                m_txd   = req_data[o*DW +: DW];
                nxt_txv = 1;
                m_stall = 0;
                if (req_last[o]) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % N;
                end
                if (use_gen) genNext(o);
            end else if (m_stall == TO) begin
                terr    = 1;
                m_owner = -1;
                m_ptr   = (o + 1) % N;
            end else if (!req_valid[o]) begin
                m_stall = (m_stall + 1 > TO) ? TO : m_stall + 1;
            end
        end
        m_txv  = nxt_txv;
        m_terr = terr;
    endtask

    task automatic cycle();
        #1;
        checkOutput();
        stepModel();
        @(negedge clk);
    endtask

    // Asserts reset between edges, pins the cleared outputs, releases on a falling edge.
    task automatic doReset(input int hold);
        #2 rst = 1'b1;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_active", grant_active, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout_err", timeout_err, 0);
        modelReset();
        repeat (hold) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        tx_ready = 1'b0;
        use_gen  = 0;
        p_valid  = 0;
        p_ready  = 100;
        clearReqs();
        @(negedge clk);
        doReset(3);

        // T1: two-byte packet from requester 0
        tx_ready = 1'b1;
        setReq(0, 1, 8'h41, 0);
        cycle();
        chk("t1_grant_active", grant_active, 1);
        chk("t1_grant_id", grant_id, 0);
        cycle();
        chk("t1_tx_valid", tx_valid, 1);
        chk("t1_byte0", tx_data, 8'h41);
        setReq(0, 1, 8'h42, 1);
        cycle();
        chk("t1_byte1", tx_data, 8'h42);
        chk("t1_release", grant_active, 0);

        // Pointer now 1: requester 1 beats 0, then the scan wraps back to 0
        setReq(0, 1, 8'h50, 1);
        setReq(1, 1, 8'h51, 1);
        cycle();
        chk("t6_first_grant", grant_id, 1);
        cycle();
        chk("t6_first_byte", tx_data, 8'h51);
        setReq(1, 0, 8'h00, 0);
        cycle();
        chk("t6_wrap_grant", grant_id, 0);
        cycle();
        chk("t6_wrap_byte", tx_data, 8'h50);
        clearReqs();

        // T2: everyone busy with one-byte packets
        for (int i = 0; i < N; i++) setReq(i, 1, 8'(8'hA0 + i), 1);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("t2_grant", grant_id, (1 + k) % N);
            cycle();
            chk("t2_byte", tx_data, 8'hA0 + ((1 + k) % N));
        end
        clearReqs();

        // T3: long backpressure holds the byte and gates ready
        setReq(1, 1, 8'h55, 0);
        cycle();
        chk("t3_grant", grant_id, 1);
        tx_ready = 1'b0;
        cycle();
        setReq(1, 1, 8'h56, 1);
        for (int j = 0; j < 10; j++) begin
            #1;
            chk("t3_ready_gated", req_ready, 4'b0000);
            chk("t3_hold_data", tx_data, 8'h55);
            chk("t3_hold_valid", tx_valid, 1);
            cycle();
        end
        tx_ready = 1'b1;
        #1;
        chk("t3_ready_open", req_ready, 4'b0010);
        cycle();
        chk("t3_second_byte", tx_data, 8'h56);
        chk("t3_release", grant_active, 0);
        clearReqs();

        // T4: requester 2 goes silent mid-packet; requester 3 waits
        setReq(2, 1, 8'h10, 0);
        cycle();
        chk("t4_grant", grant_id, 2);
        cycle();
        setReq(2, 0, 8'h00, 0);
        setReq(3, 1, 8'h33, 1);
        for (int k = 1; k <= 9; k++) begin
            cycle();
            chk("t4_timeout_err", timeout_err, (k == 9));
            chk("t4_grant_held", grant_active, (k != 9));
        end
        cycle();
        chk("t4_next_grant", grant_id, 3);
        chk("t4_err_pulse_end", timeout_err, 0);
        cycle();
        chk("t4_next_byte", tx_data, 8'h33);
        clearReqs();

        // T5: move the pointer off 0, then reset in the middle of a packet
        setReq(1, 1, 8'h71, 1);
        cycle();
        cycle();
        clearReqs();
        setReq(2, 1, 8'h01, 0);
        cycle();
        cycle();
        setReq(2, 1, 8'h02, 0);
        cycle();
        chk("t5_in_flight", tx_data, 8'h02);
        tx_ready = 1'b0;
        setReq(2, 1, 8'h03, 1);
        doReset(2);
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) setReq(i, 1, 8'(8'hC0 + i), 1);
        cycle();
        chk("t5_restart_grant", grant_id, 0);
        cycle();
        chk("t5_restart_byte", tx_data, 8'hC0);

        // Randomized traffic across valid/ready densities
        use_gen = 1;
        for (int i = 0; i < N; i++) begin
            g_left[i] = 0;
            genNext(i);
        end
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin p_valid = 90; p_ready = 100; end
                1: begin p_valid = 70; p_ready = 60;  end
                2: begin p_valid = 25; p_ready = 80;  end
                3: begin p_valid = 8;  p_ready = 90;  end
                4: begin p_valid = 95; p_ready = 30;  end
                default: begin p_valid = 50; p_ready = 50; end
            endcase
            repeat (700) begin
                applyStimulus();
                cycle();
            end
            if (ph == 2) doReset(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
